// File: rtl/biquad_coeff_loader_if.sv
// WISHBONE initiator bus between the coefficient loader and the filter register file.
interface biquad_coeff_loader_if;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_ack_i;
  logic          wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/biquad_coeff_loader.sv
// Streams a table of biquad coefficients to a register file over WISHBONE,
// optionally followed by an update-trigger write, with per-write timeout.
module biquad_coeff_loader #(
  parameter int unsigned NENTRY  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   load_wr_i,
  input  logic [3:0]             load_adr_i,
  input  logic [22:0]            load_dat_i,
  input  logic [4:0]             count_i,
  input  logic                   update_en_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  biquad_coeff_loader_if.master  wb
);

  localparam int unsigned IW = 5;                    // index/count width (0..16)
  localparam int unsigned EW = 4;                    // table address width
  localparam int unsigned TW = $clog2(TIMEOUT + 1);  // timeout counter width
  localparam int unsigned DW = 23;                   // table entry width

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_UPD  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   index_q, index_d;
  logic [IW-1:0]   count_q, count_d;
  logic            upd_q, upd_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [6:0]      adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [DW-1:0]   coef_q [NENTRY];
  logic [DW-1:0]   entry_c;
  logic [IW-1:0]   count_clamp_c;

  assign count_clamp_c = (32'(count_i) > NENTRY) ? IW'(NENTRY) : count_i;
  assign entry_c       = coef_q[index_d[EW-1:0]];

  // Coefficient table: host writes are locked out while a sequence runs.
  always_ff @(posedge wb_clk_i) begin
    if (load_wr_i && !busy_q && (32'(load_adr_i) < NENTRY)) begin
      coef_q[load_adr_i] <= load_dat_i;
    end
  end

  // State and registered-output update; reset drops the bus immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      index_q <= '0;
      count_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Sequencing: start latch, ack/err/timeout handling, entry walk.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    upd_d   = upd_q;
    err_d   = err_q;
    tmo_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          count_d = count_clamp_c;
          upd_d   = update_en_i;
          err_d   = 1'b0;
          index_d = '0;
          if (count_clamp_c != '0) begin
            state_d = S_REQ;
          end else if (update_en_i) begin
            state_d = S_UPD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_REQ, S_UPD: begin
        // Bus error takes priority over a simultaneous ack.
        if (wb.wb_err_i) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (wb.wb_ack_i) begin
          if (state_q == S_REQ) begin
            index_d = index_q + IW'(1);
            state_d = S_GAP;
          end else begin
            state_d = S_FIN;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        if (index_q < count_q) begin
          state_d = S_REQ;
        end else if (upd_q) begin
          state_d = S_UPD;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next-values derived from the upcoming state so they register with it.
  always_comb begin
    cyc_d  = 1'b0;
    stb_d  = 1'b0;
    we_d   = 1'b0;
    sel_d  = '0;
    adr_d  = '0;
    dat_d  = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_REQ: begin
        cyc_d  = 1'b1;
        stb_d  = 1'b1;
        we_d   = 1'b1;
        sel_d  = 4'hF;
        adr_d  = {entry_c[22:18], 2'b00};
        dat_d  = {14'b0, entry_c[17:0]};
        busy_d = 1'b1;
      end
      S_UPD: begin
        cyc_d  = 1'b1;
        stb_d  = 1'b1;
        we_d   = 1'b1;
        sel_d  = 4'hF;
        adr_d  = 7'h00;
        dat_d  = 32'h1;
        busy_d = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_FIN: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Randomized bench for biquad_coeff_loader with a WISHBONE responder and a
// transaction-level reference model of the write sequence and its timing.
module tb_biquad_coeff_loader;

  localparam int NENT = 16;
  localparam int TMO  = 255;

  logic        wb_clk_i    = 1'b0;
  logic        wb_rst_i    = 1'b1;
  logic        load_wr_i   = 1'b0;
  logic [3:0]  load_adr_i  = '0;
  logic [22:0] load_dat_i  = '0;
  logic [4:0]  count_i     = '0;
  logic        update_en_i = 1'b0;
  logic        start_i     = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  biquad_coeff_loader_if wb ();

  biquad_coeff_loader #(
    .NENTRY  (NENT),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .load_wr_i   (load_wr_i),
    .load_adr_i  (load_adr_i),
    .load_dat_i  (load_dat_i),
    .count_i     (count_i),
    .update_en_i (update_en_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .wb          (wb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [6:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [22:0] mtab [NENT];
  wr_t         obs [$];
  int          age = 0, wr_num = 0, cur_wr = 0, cyc_hi = 0;
  int          ack_lat = 1, fail_mode = 0, fail_idx = 0;
  bit          stray = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // WISHBONE responder: acks after ack_lat cycles, injects err/no-ack, stray strobes when idle.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      age = 0;
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
    end else if (wb.wb_cyc_o && wb.wb_stb_o) begin
      age++;
      cyc_hi++;
      if (age == 1) begin
        obs.push_back('{wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o, wb.wb_we_o});
        cur_wr = wr_num;
        wr_num++;
      end
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
      if (age == ack_lat + 1) begin
        if (fail_mode == 1 && cur_wr == fail_idx) begin
          wb.wb_err_i = 1'b1;
          wb.wb_ack_i = 1'b1;
        end else if (!(fail_mode == 2 && cur_wr == fail_idx)) begin
          wb.wb_ack_i = 1'b1;
        end
      end
    end else begin
      age = 0;
      wb.wb_ack_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      wb.wb_err_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic load_entry(input int idx, input logic [22:0] d);
    @(negedge wb_clk_i);
    load_wr_i  = 1'b1;
    load_adr_i = 4'(idx);
    load_dat_i = d;
    mtab[idx]  = d;
    @(negedge wb_clk_i);
    load_wr_i  = 1'b0;
  endtask

  task automatic load_all_random();
    for (int i = 0; i < NENT; i++) load_entry(i, 23'($urandom));
  endtask

  // One sequence: predict writes, cycle count and error, then compare.
  task automatic run_seq(input int cnt, input bit upd, input int fmode, input int fidx, input bit poke);
    int          n, w, issued, k_exp, hi_exp, k_got, cost;
    bit          err_exp, is_fail;
    logic [6:0]  ea [$];
    logic [31:0] ed [$];
    n = (cnt > NENT) ? NENT : cnt;
    for (int i = 0; i < n; i++) begin
      ea.push_back({mtab[i][22:18], 2'b00});
      ed.push_back({14'b0, mtab[i][17:0]});
    end
    if (upd) begin
      ea.push_back(7'h00);
      ed.push_back(32'h1);
    end
    w       = ea.size();
    err_exp = (fmode != 0) && (fidx < w);
    issued  = err_exp ? fidx + 1 : w;
    k_exp   = 1;
    hi_exp  = 0;
    for (int i = 0; i < issued; i++) begin
      is_fail = err_exp && (i == fidx);
      cost    = (is_fail && fmode == 2) ? TMO : ack_lat + 1;
      hi_exp += cost;
      k_exp  += cost;
      if (!is_fail && i < n) k_exp += 1;
    end

    @(negedge wb_clk_i);
    obs.delete();
    wr_num      = 0;
    cyc_hi      = 0;
    fail_mode   = fmode;
    fail_idx    = fidx;
    count_i     = 5'(cnt);
    update_en_i = upd;
    start_i     = 1'b1;
    k_got       = -1;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge wb_clk_i);
      start_i   = 1'b0;
      load_wr_i = 1'b0;
      if (t == 1) check_eq("err_clear_on_start", 32'(err_o), 32'(0));
      if (poke && t == 2) begin
        start_i    = 1'b1;
        load_wr_i  = 1'b1;
        load_adr_i = 4'(n - 1);
        load_dat_i = 23'($urandom);
      end
      if (done_o) begin
        k_got = t;
        break;
      end
    end
    start_i   = 1'b0;
    load_wr_i = 1'b0;
    check_eq("start_to_done_cycles", 32'(k_got), 32'(k_exp));
    check_eq("err_at_done", 32'(err_o), 32'(err_exp));
    check_eq("busy_at_done", 32'(busy_o), 32'(0));
    @(negedge wb_clk_i);
    check_eq("done_one_cycle", 32'(done_o), 32'(0));
    check_eq("cyc_low_after", 32'(wb.wb_cyc_o), 32'(0));
    repeat (3) @(negedge wb_clk_i);
    check_eq("err_sticky", 32'(err_o), 32'(err_exp));
    check_eq("busy_idle", 32'(busy_o), 32'(0));
    check_eq("n_writes", 32'(obs.size()), 32'(issued));
    check_eq("cyc_high_cycles", 32'(cyc_hi), 32'(hi_exp));
    for (int i = 0; i < obs.size() && i < issued; i++) begin
      check_eq("wr_adr", 32'(obs[i].adr), 32'(ea[i]));
      check_eq("wr_dat", obs[i].dat, ed[i]);
      check_eq("wr_sel", 32'(obs[i].sel), 32'(4'hF));
      check_eq("wr_we", 32'(obs[i].we), 32'(1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, nn, wl, fm, fi, r;
    bit up, pk;

    // Reset values.
    repeat (2) @(negedge wb_clk_i);
    check_eq("rst_cyc", 32'(wb.wb_cyc_o), 32'(0));
    check_eq("rst_stb", 32'(wb.wb_stb_o), 32'(0));
    check_eq("rst_we", 32'(wb.wb_we_o), 32'(0));
    check_eq("rst_adr", 32'(wb.wb_adr_o), 32'(0));
    check_eq("rst_dat", wb.wb_dat_o, 32'(0));
    check_eq("rst_sel", 32'(wb.wb_sel_o), 32'(0));
    check_eq("rst_busy", 32'(busy_o), 32'(0));
    check_eq("rst_done", 32'(done_o), 32'(0));
    check_eq("rst_err", 32'(err_o), 32'(0));
    wb_rst_i = 1'b0;

    // Three known entries plus update write.
    load_entry(0, {5'd1, 18'h1FFFF});
    load_entry(1, {5'd2, 18'h00001});
    load_entry(2, {5'd4, 18'h20000});
    ack_lat = 1;
    run_seq(3, 1'b1, 0, 0, 1'b0);
    if (obs.size() == 4) begin
      check_eq("dir_adr0", 32'(obs[0].adr), 32'(7'h04));
      check_eq("dir_dat0", obs[0].dat, 32'h0001_FFFF);
      check_eq("dir_adr2", 32'(obs[2].adr), 32'(7'h10));
      check_eq("dir_dat2", obs[2].dat, 32'h0002_0000);
      check_eq("dir_upd_adr", 32'(obs[3].adr), 32'(7'h00));
      check_eq("dir_upd_dat", obs[3].dat, 32'h1);
    end else begin
      check_eq("dir_write_count", 32'(obs.size()), 32'(4));
    end

    // Empty sequence: no bus activity, immediate done.
    run_seq(0, 1'b0, 0, 0, 1'b0);

    // No ack at all: timeout on the first write, no update write.
    load_all_random();
    run_seq(2, 1'b1, 2, 0, 1'b0);

    // Bus error on the 2nd of 4 entries, then a clean run clears err_o.
    run_seq(4, 1'b1, 1, 1, 1'b0);
    run_seq(4, 1'b0, 0, 0, 1'b0);

    // Start and table write while busy are ignored.
    run_seq(5, 1'b1, 0, 0, 1'b1);
    run_seq(5, 1'b0, 0, 0, 1'b0);

    // Count above the table depth is clamped.
    run_seq(31, 1'b1, 0, 0, 1'b0);

    // Randomized sequences.
    for (int it = 0; it < 20; it++) begin
      if (it % 5 == 0) load_all_random();
      cnt     = $urandom_range(0, 31);
      up      = 1'($urandom_range(0, 1));
      ack_lat = $urandom_range(0, 3);
      stray   = 1'($urandom_range(0, 1));
      nn      = (cnt > NENT) ? NENT : cnt;
      wl      = nn + (up ? 1 : 0);
      r       = $urandom_range(0, 9);
      fm      = (wl == 0 || r < 7) ? 0 : ((r < 9) ? 1 : 2);
      fi      = (wl == 0) ? 0 : $urandom_range(0, wl - 1);
      pk      = (nn >= 2) && ($urandom_range(0, 2) == 0);
      run_seq(cnt, up, fm, fi, pk);
    end
    stray = 1'b0;

    // Asynchronous reset while the bus is active, then a normal run.
    ack_lat   = 3;
    fail_mode = 0;
    @(negedge wb_clk_i);
    count_i     = 5'd3;
    update_en_i = 1'b1;
    start_i     = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    check_eq("cyc_before_rst", 32'(wb.wb_cyc_o), 32'(1));
    #2 wb_rst_i = 1'b1;
    #1;
    check_eq("async_rst_cyc", 32'(wb.wb_cyc_o), 32'(0));
    check_eq("async_rst_stb", 32'(wb.wb_stb_o), 32'(0));
    check_eq("async_rst_busy", 32'(busy_o), 32'(0));
    check_eq("async_rst_dat", wb.wb_dat_o, 32'(0));
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    load_all_random();
    ack_lat = 1;
    run_seq(3, 1'b1, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/biquad_coeff_loader.md
BIQUAD_COEFF_LOADER -- requirements
Module: biquad_coeff_loader

Interface
REQ-001 The block SHALL have parameter NENTRY, default 16, the coefficient table depth.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for an ack per bus write.
REQ-003 The block SHALL have port wb_clk_i, input, 1 bit: the only clock. All logic is on its rising edge.
REQ-004 The block SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port load_wr_i, input, 1 bit: table write strobe.
REQ-006 The block SHALL have port load_adr_i, input, 4 bits: table entry index.
REQ-007 The block SHALL have port load_dat_i, input, 23 bits: [22:18] target word address (target byte address bits [6:2]); [17:0] coefficient.
REQ-008 The block SHALL have port count_i, input, 5 bits: number of entries to send, 0..16.
REQ-009 The block SHALL have port update_en_i, input, 1 bit: append an update write after the entries.
REQ-010 The block SHALL have port start_i, input, 1 bit: single-cycle start pulse.
REQ-011 The block SHALL have ports busy_o (1), done_o (1) and err_o (1), all outputs: sequence active, one-cycle completion pulse, and sticky error.
REQ-012 The block SHALL have WISHBONE initiator outputs wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_adr_o (7), wb_dat_o (32) and wb_sel_o (4).
REQ-013 The block SHALL have WISHBONE initiator inputs wb_ack_i (1) and wb_err_i (1).

Function
REQ-014 Table: NENTRY x 23-bit, written on load_wr_i when not busy; writes while busy_o=1 SHALL be ignored.
REQ-015 States: IDLE, REQ, GAP, UPD, FIN.
REQ-016 IDLE: on start_i, latch count_i and update_en_i, clear err_o, set index=0, busy_o=1. Next state: REQ if count>0; UPD if count=0 and update_en=1; otherwise FIN.
REQ-017 REQ: wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hF, wb_adr_o={entry[22:18],2'b00}, wb_dat_o={14'b0,entry[17:0]}, all registered.
REQ-018 REQ exit on wb_ack_i: go to GAP the next cycle with cyc/stb low and index+1.
REQ-019 GAP lasts exactly 1 cycle. Next state: REQ if index<count; else UPD if update_en; else FIN.
REQ-020 UPD: same strobes as REQ, with wb_adr_o=7'h00 and wb_dat_o=32'h1. On ack go to FIN.
REQ-021 FIN: done_o=1 for exactly 1 cycle, busy_o=0 in the same cycle, then IDLE.
REQ-022 Timeout: a counter clears on entry to REQ/UPD and increments each cycle without ack. When it reaches TIMEOUT, set err_o, drop cyc/stb next cycle, go to FIN. No further writes in that sequence.
REQ-023 wb_err_i in REQ/UPD SHALL be handled identically to timeout.
REQ-024 wb_ack_i/wb_err_i SHALL be ignored outside REQ/UPD. If ack and err arrive together, err SHALL win.
REQ-025 start_i while busy_o=1 SHALL be ignored.
REQ-026 count_i>NENTRY SHALL be clamped to NENTRY.
REQ-027 Total cycles from start to done for N entries with 1-cycle ack latency and update enabled: 1+3N+2+1.
REQ-028 err_o SHALL hold until the next accepted start_i or reset.

Reset
REQ-029 wb_rst_i SHALL asynchronously force IDLE and set wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0, index=0 and the timeout counter to 0.
REQ-030 Reset mid-transfer SHALL drop wb_cyc_o without waiting for the clock. Table contents are undefined after reset.

Verification
REQ-031 Load 3 entries {0x04,0x1FFFF}, {0x08,0x00001}, {0x10,0x20000}; count=3, update_en=1; ack 1 cycle after stb -> writes to 0x04/0x08/0x10 then 0x00 with data 1, cyc low 1 cycle between each, done_o pulse, err_o=0.
REQ-032 count=0, update_en=0, start -> no cyc asserted, done_o pulses 2 cycles after start.
REQ-033 ack never returned, TIMEOUT=255 -> cyc drops after 255 cycles, err_o=1, done_o pulses, no update write.
REQ-034 wb_err_i on 2nd of 4 entries -> entries 3 and 4 not issued, err_o=1. The next start clears err_o.
REQ-035 Assert wb_rst_i asynchronously while wb_cyc_o=1 -> wb_cyc_o=0 before the next clock edge. A start after reset runs normally.
REQ-036 start_i and load_wr_i pulsed while busy -> no restart, and the table entry is unchanged (verified by the written data).
